// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates two writeback requesters (0 = ALU, 1 = load unit) onto the
// single register-file write port and keeps a busy scoreboard of
// destination registers with outstanding writes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_rd/_dat    writeback requests
//   req{0,1}_ready             combinational grant (handshake = valid & ready)
//   alloc_valid, alloc_rd      issue stage reserves a destination register
//   rs1, rs2                   source registers to check
//   rs1_busy, rs2_busy         combinational scoreboard lookup
//   rd, rd_we, rd_wd           registered register-file write port
module regfile_wb_arbiter #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [AddressBitWidth-1:0] req0_rd,
  input  logic [DataBitWidth-1:0]    req0_dat,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [AddressBitWidth-1:0] req1_rd,
  input  logic [DataBitWidth-1:0]    req1_dat,
  output logic                       req1_ready,
  input  logic                       alloc_valid,
  input  logic [AddressBitWidth-1:0] alloc_rd,
  input  logic [AddressBitWidth-1:0] rs1,
  input  logic [AddressBitWidth-1:0] rs2,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [AddressBitWidth-1:0] rd,
  output logic                       rd_we,
  output logic [DataBitWidth-1:0]    rd_wd
);

  localparam int Depth = 1 << AddressBitWidth;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_e;

  last_e                      last_r;
  logic                       grant0_s;
  logic                       grant1_s;
  logic [AddressBitWidth-1:0] rd_r;
  logic                       rd_we_r;
  logic [DataBitWidth-1:0]    rd_wd_r;
  logic [Depth-1:0]           busy_r;
  logic [Depth-1:0]           set_s;
  logic [Depth-1:0]           clr_s;
  logic [Depth-1:0]           busy_nxt_s;

  // One-hot decode of a register index into a scoreboard mask.
  function automatic logic [Depth-1:0] onehot(input logic [AddressBitWidth-1:0] idx);
    onehot = {{(Depth-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin grant: a lone requester always wins; on contention the
  // requester that was not granted last wins. Reset masks both grants.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        if (last_r == LAST1) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Register the granted write; a write to x0 is consumed without a write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r    <= {AddressBitWidth{1'b0}};
      rd_we_r <= 1'b0;
      rd_wd_r <= {DataBitWidth{1'b0}};
      last_r  <= LAST1;
    end else if (grant0_s) begin
      rd_r    <= req0_rd;
      rd_we_r <= (req0_rd != {AddressBitWidth{1'b0}});
      rd_wd_r <= req0_dat;
      last_r  <= LAST0;
    end else if (grant1_s) begin
      rd_r    <= req1_rd;
      rd_we_r <= (req1_rd != {AddressBitWidth{1'b0}});
      rd_wd_r <= req1_dat;
      last_r  <= LAST1;
    end else begin
      rd_we_r <= 1'b0;
    end
  end

  assign rd    = rd_r;
  assign rd_we = rd_we_r;
  assign rd_wd = rd_wd_r;

  // Scoreboard next state: the retiring write clears its bit, a new
  // reservation sets its bit (set applied last so it wins), x0 never busy.
  always_comb begin
    set_s      = {Depth{1'b0}};
    clr_s      = {Depth{1'b0}};
    if (alloc_valid && (alloc_rd != {AddressBitWidth{1'b0}})) begin
      set_s = onehot(alloc_rd);
    end else begin
      set_s = {Depth{1'b0}};
    end
    if (rd_we_r) begin
      clr_s = onehot(rd_r);
    end else begin
      clr_s = {Depth{1'b0}};
    end
    busy_nxt_s = ((busy_r & ~clr_s) | set_s) & ~{{(Depth-1){1'b0}}, 1'b1};
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {Depth{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Hazard lookups read the stored scoreboard only (no bypass).
  assign rs1_busy = busy_r[rs1];
  assign rs2_busy = busy_r[rs2];

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter AddressBitWidth, default 5, register address width.
REQ-002 SHALL have parameter DataBitWidth, default 32, register data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  writeback request pending from requester 0 (ALU) / 1 (load unit).
REQ-006 SHALL have ports req0_rd/req1_rd  input  AddressBitWidth  destination register of each request.
REQ-007 SHALL have ports req0_dat/req1_dat  input  DataBitWidth  write data of each request.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle (combinational grant).
REQ-009 SHALL have port alloc_valid  input  1  issue stage reserves a destination register.
REQ-010 SHALL have port alloc_rd  input  AddressBitWidth  register being reserved.
REQ-011 SHALL have ports rs1/rs2  input  AddressBitWidth  source registers to check for hazards.
REQ-012 SHALL have ports rs1_busy/rs2_busy  output  1  source register has a write outstanding (combinational).
REQ-013 SHALL have port rd  output  AddressBitWidth  register file destination, registered.
REQ-014 SHALL have port rd_we  output  1  register file write enable, registered.
REQ-015 SHALL have port rd_wd  output  DataBitWidth  register file write data, registered.

Function
REQ-016 A handshake on requester i SHALL complete in a cycle where reqi_valid and reqi_ready are both high; reqi_ready SHALL never be high while reqi_valid is low.
REQ-017 At most one of req0_ready/req1_ready SHALL be high per cycle (single write port).
REQ-018 Arbitration SHALL be round-robin via a one-bit state LAST in {LAST0, LAST1} recording the last granted requester.
REQ-019 Only one valid: that requester SHALL be granted regardless of LAST.
REQ-020 Both valid: the requester not equal to LAST SHALL be granted.
REQ-021 LAST SHALL change only on a completed handshake, to the granted requester; no grant leaves LAST unchanged.
REQ-022 A handshake in cycle N SHALL produce rd/rd_wd = granted rd/dat and rd_we = 1 in cycle N+1 (latency one cycle).
REQ-023 No handshake in cycle N SHALL give rd_we = 0 in cycle N+1; rd/rd_wd SHALL then hold previous values.
REQ-024 A handshake with rd = 0 SHALL be accepted and consumed but SHALL drive rd_we = 0 in cycle N+1.
REQ-025 A scoreboard of 2**AddressBitWidth busy bits SHALL be kept; bit 0 SHALL read 0 always.
REQ-026 alloc_valid with alloc_rd != 0 SHALL set busy[alloc_rd] at the clock edge.
REQ-027 rd_we = 1 SHALL clear busy[rd] at the same edge the register file stores rd_wd.
REQ-028 Set and clear of the same bit at one edge: set SHALL win (bit remains 1).
REQ-029 rs1_busy = busy[rs1], rs2_busy = busy[rs2], combinational, no bypass from rd_we.
REQ-030 Writeback for a register not busy SHALL still be written; the bit SHALL remain 0.
REQ-031 Back-to-back handshakes SHALL sustain one register write per cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force rd_we = 0, rd = 0, rd_wd = 0, LAST = LAST1, all busy bits = 0.
REQ-033 During reset req0_ready and req1_ready SHALL be 0 and no handshake SHALL occur.
REQ-034 Reset asserted mid-operation SHALL drop any registered write (rd_we = 0) and clear all reservations.
REQ-035 After rst_n rises, first both-valid cycle SHALL grant requester 0.

Verification
REQ-036 After reset, req0 (rd=5, dat=0x11) and req1 (rd=6, dat=0x22) held valid 4 cycles -> grants 0,1,0,1; rd_we=1 each following cycle with rd 5,6,5,6.
REQ-037 Only req1 valid 3 consecutive cycles (rd=7, dat=0xA0..0xA2) -> req1_ready=1 each cycle; rd_we=1 three cycles, rd_wd 0xA0,0xA1,0xA2.
REQ-038 alloc rd=9; next cycle rs1=9 -> rs1_busy=1; req0 rd=9 accepted cycle N -> rd_we in N+1, rs1_busy=0 from N+2.
REQ-039 alloc rd=3 in same cycle rd_we=1 with rd=3 -> busy[3]=1 afterwards.
REQ-040 req0 rd=0 dat=0xFF -> req0_ready=1, rd_we=0 next cycle; alloc rd=0 -> rs1=0 gives rs1_busy=0.
REQ-041 busy[4] set and rd_we pending, rst_n pulsed low asynchronously -> rd_we=0 and rs2_busy(rs2=4)=0 immediately.
